// File: rtl/matrix_mult_pkg.sv
// Shared types and defaults for the matrix_mult systolic sequencer.
// No logic of its own; no latency.
// No handshake; consumers size their counters from the helper here.
package matrix_mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    localparam int N_DEF     = 4;
    localparam int FLUSH_DEF = 8;

    // The phase counter is shared by FEED (2N-1 cycles) and FLUSH, so it
    // must hold the larger of the two phase lengths minus one.
    function automatic int phase_cnt_width(input int n, input int flush_cyc);
        int span;
        span = (2 * n - 1 > flush_cyc) ? 2 * n - 1 : flush_cyc;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/skew_window_gen.sv
// Maps the feed phase counter to the skewed per-lane FIFO read strobes.
// Purely combinational, zero latency.
// No backpressure; strobes are forced low whenever vld_i is low.
module skew_window_gen #(
    parameter int N  = 4,
    parameter int TW = 3
) (
    input  logic [TW-1:0] t_i,
    input  logic          vld_i,
    output logic [N-1:0]  win_o
);

    // One extra bit so the upper bound i+N never overflows the compare width.
    logic [TW:0] t_ext;
    assign t_ext = {1'b0, t_i};

    // Lane i is read on N consecutive cycles starting at t == i.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [TW:0] LO = (TW + 1)'(i);
        localparam logic [TW:0] HI = (TW + 1)'(i + N);
        logic lo_ok;
        if (i == 0) begin : g_first
            assign lo_ok = 1'b1;
        end else begin : g_rest
            assign lo_ok = (t_ext >= LO);
        end
        assign win_o[i] = vld_i && lo_ok && (t_ext < HI);
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequences an N x N systolic multiply: arm, skewed feed, flush, row-major drain.
// First result write 2N-1+FLUSH_CYC cycles after ARM exit; full run 31 cycles at defaults.
// out_full_i stalls the drain in place (count holds, nothing lost); start is ignored mid-run.
module systolic_seq_ctrl
    import matrix_mult_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int FLUSH_CYC = FLUSH_DEF,
    parameter int CW        = $clog2(N * N)
) (
    input  logic          clock_i,
    input  logic          resetn_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [2*N-1:0] in_full_i,
    input  logic          out_full_i,
    output logic [N-1:0]  rd_a_o,
    output logic [N-1:0]  rd_b_o,
    output logic          reg_en_o,
    output logic          mult_en_o,
    output logic          add_en_o,
    output logic          wr_out_o,
    output logic [CW-1:0] count_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int            TW           = phase_cnt_width(N, FLUSH_CYC);
    localparam logic [TW-1:0] T_FEED_LAST  = TW'(2 * N - 2);
    localparam logic [TW-1:0] T_FLUSH_LAST = TW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(N * N - 1);

    seq_state_t    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [CW-1:0] count_q, count_d;
    logic          add_en_q, add_en_d;

    logic          feeding;
    logic          array_run;
    logic [N-1:0]  rd_win;

    assign feeding   = (state_q == FEED);
    assign array_run = (state_q == FEED) || (state_q == FLUSH);

    // One window generator feeds both operand sides: A rows and B columns
    // share the same skew.
    skew_window_gen #(
        .N  (N),
        .TW (TW)
    ) u_skew (
        .t_i   (t_q),
        .vld_i (feeding),
        .win_o (rd_win)
    );

    // State, phase counter, result index and the delayed accumulate enable.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= IDLE;
            t_q      <= '0;
            count_q  <= '0;
            add_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            count_q  <= count_d;
            add_en_q <= add_en_d;
        end
    end

    // Next-state logic; clear overrides every transition and aborts the run.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        count_d  = count_q;
        add_en_d = array_run && !clear_i;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ARM;
            end
            ARM: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else if (&in_full_i) begin
                    state_d = FEED;
                    t_d     = '0;
                    count_d = '0;
                end
            end
            FEED: begin
                if (t_q == T_FEED_LAST) begin
                    state_d = FLUSH;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            FLUSH: begin
                if (t_q == T_FLUSH_LAST) begin
                    state_d = DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                // The last index is written without advancing, so count
                // never wraps and DONE reports the final index.
                if (!out_full_i) begin
                    if (count_q == CNT_LAST) state_d = DONE;
                    else                     count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            t_d     = '0;
            count_d = '0;
        end
    end

    assign rd_a_o    = rd_win;
    assign rd_b_o    = rd_win;
    assign reg_en_o  = array_run;
    assign mult_en_o = array_run;
    assign add_en_o  = add_en_q;
    assign wr_out_o  = (state_q == DRAIN) && !out_full_i;
    assign count_o   = count_q;
    assign busy_o    = (state_q != IDLE) && (state_q != DONE);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl with a phase/write-count reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Random out_full stalls and random ignored inputs are applied during runs.
module tb_systolic_seq_ctrl;
    import matrix_mult_pkg::*;

    localparam int N        = N_DEF;
    localparam int FL       = FLUSH_DEF;
    localparam int CW       = $clog2(N * N);
    localparam int FEED_LEN = 2 * N - 1;
    localparam int NRES     = N * N;

    logic          clk;
    logic          resetn;
    logic          clear;
    logic          start;
    logic [2*N-1:0] in_full;
    logic          out_full;
    logic [N-1:0]  rd_a;
    logic [N-1:0]  rd_b;
    logic          reg_en;
    logic          mult_en;
    logic          add_en;
    logic          wr_out;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    systolic_seq_ctrl #(
        .N         (N),
        .FLUSH_CYC (FL),
        .CW        (CW)
    ) dut (
        .clock_i    (clk),
        .resetn_i   (resetn),
        .clear_i    (clear),
        .start_i    (start),
        .in_full_i  (in_full),
        .out_full_i (out_full),
        .rd_a_o     (rd_a),
        .rd_b_o     (rd_b),
        .reg_en_o   (reg_en),
        .mult_en_o  (mult_en),
        .add_en_o   (add_en),
        .wr_out_o   (wr_out),
        .count_o    (count),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Skewed read pattern for the default N=4: lane i is read on cycles i..i+3.
    function automatic logic [N-1:0] exp_rd(input int k);
        case (k)
            0:       return 4'b0001;
            1:       return 4'b0011;
            2:       return 4'b0111;
            3:       return 4'b1111;
            4:       return 4'b1110;
            5:       return 4'b1100;
            6:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk_quiet(input string tag, input bit exp_done, input int exp_cnt);
        chk({tag, "_rd_a"}, 32'(rd_a), 32'(0));
        chk({tag, "_rd_b"}, 32'(rd_b), 32'(0));
        chk({tag, "_reg_en"}, 32'(reg_en), 32'(0));
        chk({tag, "_mult_en"}, 32'(mult_en), 32'(0));
        chk({tag, "_add_en"}, 32'(add_en), 32'(0));
        chk({tag, "_wr_out"}, 32'(wr_out), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    endtask

    // Starts at posedge+1 in IDLE; ends at the falling edge of the first
    // DONE cycle, or of the IDLE cycle that follows a clear.
    // stall_mode: 0 none, 1 random, 2 three cycles at write index 5.
    task automatic run(input int arm_wait, input int stall_mode, input int clear_at);
        int  k, writes, stalls, dstall, done_k;
        bit  prev_men, in_feed, in_flush, in_drain, in_done, do_clear;
        start    = 1'b1;
        clear    = 1'b0;
        out_full = 1'($urandom);
        if (arm_wait == 0) in_full = '1;
        else               in_full = {1'b0, 7'($urandom)};
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        adv();
        for (int w = 0; w < arm_wait; w++) begin
            in_full = {1'b0, 7'($urandom)};
            @(negedge clk);
            chk("arm_wait_rd_a", 32'(rd_a), 32'(0));
            chk("arm_wait_busy", 32'(busy), 32'(1));
            adv();
        end
        in_full = '1;
        @(negedge clk);
        chk("arm_rd_b", 32'(rd_b), 32'(0));
        chk("arm_busy", 32'(busy), 32'(1));
        chk("arm_reg_en", 32'(reg_en), 32'(0));
        chk("arm_count", 32'(count), 32'(0));
        adv();
        k = 0; writes = 0; stalls = 0; dstall = 0; prev_men = 1'b0; done_k = -1;
        forever begin
            if (k > 400) begin
                n_vec++;
                n_err++;
                $error("FAIL run_timeout: observed no DONE after %0d cycles, required DONE", k);
                break;
            end
            in_feed  = (k < FEED_LEN);
            in_flush = (k >= FEED_LEN) && (k < FEED_LEN + FL);
            in_done  = (writes == NRES);
            in_drain = !in_feed && !in_flush && !in_done;
            in_full  = 8'($urandom);
            start    = (k < FEED_LEN + FL) ? 1'($urandom) : 1'b1;
            if (in_drain) begin
                case (stall_mode)
                    1:       out_full = ($urandom_range(0, 3) == 0);
                    2:       out_full = (writes == 5) && (dstall < 3);
                    default: out_full = 1'b0;
                endcase
                if (stall_mode == 2 && out_full) dstall++;
            end else begin
                out_full = 1'($urandom);
            end
            do_clear = in_drain && (writes == clear_at);
            clear    = do_clear;
            @(negedge clk);
            chk("run_rd_a", 32'(rd_a), 32'(exp_rd(k)));
            chk("run_rd_b", 32'(rd_b), 32'(exp_rd(k)));
            chk("run_reg_en", 32'(reg_en), 32'(in_feed || in_flush));
            chk("run_mult_en", 32'(mult_en), 32'(in_feed || in_flush));
            chk("run_add_en", 32'(add_en), 32'(prev_men));
            chk("run_wr_out", 32'(wr_out), 32'(in_drain && !out_full));
            chk("run_count", 32'(count), in_done ? 32'(NRES - 1) : (in_drain ? 32'(writes) : 32'(0)));
            chk("run_busy", 32'(busy), 32'(!in_done));
            chk("run_done", 32'(done), 32'(in_done));
            if (in_done) begin
                done_k = k;
                break;
            end
            adv();
            if (do_clear) begin
                clear = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk_quiet("after_clear", 1'b0, 0);
                break;
            end
            if (in_drain && out_full) stalls++;
            if (in_drain && !out_full) writes++;
            prev_men = in_feed || in_flush;
            k++;
        end
        if (clear_at < 0) chk("done_cycle", 32'(done_k), 32'(FEED_LEN + FL + NRES + stalls));
    endtask

    // From the falling edge of a DONE cycle: keep start high with full FIFOs
    // and confirm the sequencer does not retrigger.
    task automatic hold_done(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            adv();
            start   = 1'b1;
            in_full = '1;
            @(negedge clk);
            chk_quiet("hold_done", 1'b1, NRES - 1);
        end
    endtask

    // From the falling edge of a DONE cycle: drop start and reach IDLE.
    task automatic go_idle();
        adv();
        start    = 1'b0;
        in_full  = '0;
        out_full = 1'b0;
        @(negedge clk);
        chk("drop_start_done", 32'(done), 32'(1));
        adv();
        @(negedge clk);
        chk_quiet("back_idle", 1'b0, 0);
    endtask

    initial begin
        resetn   = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        in_full  = '0;
        out_full = 1'b0;
        #1;
        chk_quiet("reset", 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset", 1'b0, 0);

        // Nominal run with every FIFO already full.
        adv();
        run(0, 0, -1);
        go_idle();

        // Start before B column 3 is full; feed waits for it.
        adv();
        run(3, 0, -1);
        go_idle();

        // Three-cycle backpressure at write index 5.
        adv();
        run(1, 2, -1);
        // Start held after DONE must not retrigger.
        hold_done(4);
        go_idle();

        // Clear in the middle of the drain, then a clean run.
        adv();
        run(0, 0, 9);
        adv();
        run(2, 1, -1);
        go_idle();

        // Start dropped while armed returns to IDLE.
        adv();
        start   = 1'b1;
        in_full = 8'h7f;
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'(0));
        adv();
        start = 1'b0;
        @(negedge clk);
        chk("abort_arm_busy", 32'(busy), 32'(1));
        adv();
        @(negedge clk);
        chk_quiet("abort_idle", 1'b0, 0);

        // Asynchronous reset in the middle of FEED.
        adv();
        start   = 1'b1;
        in_full = '1;
        @(negedge clk);
        chk("rst_idle_busy", 32'(busy), 32'(0));
        repeat (4) adv();
        @(negedge clk);
        chk("rst_feed_rd_a", 32'(rd_a), 32'(4'b0111));
        chk("rst_feed_mult_en", 32'(mult_en), 32'(1));
        #2;
        resetn = 1'b0;
        #1;
        chk_quiet("rst_async", 1'b0, 0);
        adv();
        resetn  = 1'b1;
        start   = 1'b0;
        in_full = '0;
        @(negedge clk);
        chk_quiet("rst_release", 1'b0, 0);

        // Randomized runs with random stalls.
        for (int r = 0; r < 3; r++) begin
            adv();
            run($urandom_range(0, 3), 1, -1);
            go_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
